ifu_fetch_ctrl: RTL

IFU_FETCH_CTRL -- requirements
Module: ifu_fetch_ctrl

---
 rtl/ifu_fetch_ctrl_pkg.sv | 29 ++
 rtl/ifu_ibuf.sv | 66 ++++++
 rtl/ifu_fetch_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/ifu_fetch_ctrl_pkg.sv
// ifu_fetch_ctrl_pkg
//   Shared widths, fetch FSM state encoding and the redirect-target helper
//   used by the instruction-fetch controller and its output buffer.
package ifu_fetch_ctrl_pkg;

    localparam int PC_SIZE     = 32;
    localparam int INSTR_WIDTH = 32;

    // Sequential fetch stride (one 32-bit instruction).
    localparam logic [PC_SIZE-1:0] PC_STEP = PC_SIZE'(4);

    // ST_REQ   : a fetch request is being driven, nothing outstanding
    // ST_WAIT  : one request outstanding, its response will be kept
    // ST_DRAIN : one request outstanding, its response will be dropped
    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    // Redirect target: plain modular add, the carry out is discarded.
    function automatic logic [PC_SIZE-1:0] flush_target(
        input logic [PC_SIZE-1:0] op1,
        input logic [PC_SIZE-1:0] op2
    );
        return op1 + op2;
    endfunction

endpackage

// File: rtl/ifu_ibuf.sv
// ifu_ibuf
//   One-entry instruction/PC holding register between the fetch response
//   and the decode stage.
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     load_i          capture instr_i/pc_i this cycle (entry becomes valid)
//     clear_i         discard the entry (wins over load_i)
//     instr_i, pc_i   data to capture
//     ready_i         consumer ready; valid_o & ready_i pops the entry
//     valid_o         entry holds an instruction
//     instr_o, pc_o   held instruction and its PC
module ifu_ibuf
    import ifu_fetch_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_i,
    input  logic                   clear_i,
    input  logic [INSTR_WIDTH-1:0] instr_i,
    input  logic [PC_SIZE-1:0]     pc_i,
    input  logic                   ready_i,
    output logic                   valid_o,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic [PC_SIZE-1:0]     pc_o
);

    logic                   valid_q, valid_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [PC_SIZE-1:0]     pc_q, pc_d;

    // Pop on handshake, a same-cycle load refills, a clear empties
    // regardless of either.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
        if (load_i) begin
            valid_d = 1'b1;
            instr_d = instr_i;
            pc_d    = pc_i;
        end
        if (clear_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// ifu_fetch_ctrl
//   Instruction-fetch controller: issues one fetch request at a time,
//   buffers the in-order response in ifu_ibuf and hands it to decode.
//   Branch-mispredict flushes redirect the fetch PC immediately and cause
//   any in-flight response to be discarded.
//   Ports:
//     clk, rst                    clock, synchronous active-high reset
//     pipe_flush_req/_ack         flush request, acknowledged same cycle
//     pipe_flush_add_op1/op2      redirect target = op1 + op2
//     ifetch_req_*                request to instruction memory
//     ifetch_rsp_*                response from instruction memory
//     ifu_o_*                     instruction + PC to decode
//     dbg_state_o                 current fetch FSM state
//   Every valid/ready pair transfers on a rising edge where both are 1;
//   the request valid may be withdrawn before the handshake (on flush).
module ifu_fetch_ctrl
    import ifu_fetch_ctrl_pkg::*;
#(
    parameter logic [PC_SIZE-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pipe_flush_req,
    input  logic [PC_SIZE-1:0]     pipe_flush_add_op1,
    input  logic [PC_SIZE-1:0]     pipe_flush_add_op2,
    output logic                   pipe_flush_ack,
    output logic                   ifetch_req_valid,
    input  logic                   ifetch_req_ready,
    output logic [PC_SIZE-1:0]     ifetch_req_pc,
    input  logic                   ifetch_rsp_valid,
    output logic                   ifetch_rsp_ready,
    input  logic [INSTR_WIDTH-1:0] ifetch_rsp_instr,
    output logic                   ifu_o_valid,
    input  logic                   ifu_o_ready,
    output logic [INSTR_WIDTH-1:0] ifu_o_instr,
    output logic [PC_SIZE-1:0]     ifu_o_pc,
    output fetch_state_e           dbg_state_o
);

    fetch_state_e       state_q, state_d;
    logic [PC_SIZE-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_SIZE-1:0] out_pc_q, out_pc_d;

    logic flush;
    logic buf_valid;
    logic buf_load;

    assign flush          = pipe_flush_req & ~rst;
    assign pipe_flush_ack = flush;

    always_comb begin
        state_d          = state_q;
        fetch_pc_d       = fetch_pc_q;
        out_pc_d         = out_pc_q;
        ifetch_req_valid = 1'b0;
        ifetch_rsp_ready = 1'b0;
        buf_load         = 1'b0;

        case (state_q)
            ST_REQ: begin
                ifetch_req_valid = 1'b1;
                if (ifetch_req_ready) begin
                    out_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + PC_STEP;
                    // A request accepted in a flush cycle is stale already.
                    state_d    = flush ? ST_DRAIN : ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Accept only if the buffer is empty or emptying now.
                ifetch_rsp_ready = ~buf_valid | ifu_o_ready;
                if (ifetch_rsp_valid && ifetch_rsp_ready) begin
                    buf_load = ~flush;
                    state_d  = ST_REQ;
                end else if (flush) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                ifetch_rsp_ready = 1'b1;
                // The discarded response completing here leaves nothing
                // outstanding, so a flush this cycle must not keep DRAIN.
                if (ifetch_rsp_valid) begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase

        // Redirect beats the sequential increment.
        if (flush) begin
            fetch_pc_d = flush_target(pipe_flush_add_op1, pipe_flush_add_op2);
        end

        if (rst) begin
            ifetch_req_valid = 1'b0;
            ifetch_rsp_ready = 1'b0;
            buf_load         = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_REQ;
            fetch_pc_q <= RESET_PC;
            out_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            out_pc_q   <= out_pc_d;
        end
    end

    assign ifetch_req_pc = fetch_pc_q;
    assign dbg_state_o   = state_q;

    ifu_ibuf u_ibuf (
        .clk     (clk),
        .rst     (rst),
        .load_i  (buf_load),
        .clear_i (flush),
        .instr_i (ifetch_rsp_instr),
        .pc_i    (out_pc_q),
        .ready_i (ifu_o_ready),
        .valid_o (buf_valid),
        .instr_o (ifu_o_instr),
        .pc_o    (ifu_o_pc)
    );

    assign ifu_o_valid = buf_valid & ~rst;

endmodule
